// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// sticky overflow/underflow errors and selectable first-word-fall-through read.
module sync_fifo_ext #(
  parameter int WIDTH  = 32,
  parameter int ADDR   = 4,
  parameter int FWFT   = 0,
  parameter int AF_LVL = (1 << ADDR) - 2,
  parameter int AE_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int            DEPTH  = 1 << ADDR;
  localparam logic [ADDR:0] ONE    = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR:0] AF_CNT = AF_LVL[ADDR:0];
  localparam logic [ADDR:0] AE_CNT = AE_LVL[ADDR:0];

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR:0]    wr_ptr_r, rd_ptr_r, count_r;
  logic             empty_r, full_r, ae_r, af_r, ovf_r, unf_r;

  logic             wr_acc_s, rd_acc_s;
  logic [ADDR:0]    wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
  logic             empty_nxt_s, full_nxt_s, ae_nxt_s, af_nxt_s, ovf_nxt_s, unf_nxt_s;

  // Accept decisions, next pointers/count and next-state flags
  always_comb begin
    wr_acc_s     = wr_en & ~full_r;
    rd_acc_s     = rd_en & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + ONE;
      2'b01:   count_nxt_s = count_r - ONE;
      default: count_nxt_s = count_r;
    endcase
    // Extra wrap bit distinguishes full from empty when the low bits match
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[ADDR-1:0] == rd_ptr_nxt_s[ADDR-1:0]) &&
                  (wr_ptr_nxt_s[ADDR] != rd_ptr_nxt_s[ADDR]);
    ae_nxt_s    = (count_nxt_s <= AE_CNT);
    af_nxt_s    = (count_nxt_s >= AF_CNT);
    ovf_nxt_s   = ovf_r | (wr_en & full_r);
    unf_nxt_s   = unf_r | (rd_en & empty_r);
  end

  // Control state register; clr restores reset values and overrides everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ae_r     <= 1'b1;
      af_r     <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else if (clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
      ae_r     <= 1'b1;
      af_r     <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      empty_r  <= empty_nxt_s;
      full_r   <= full_nxt_s;
      ae_r     <= ae_nxt_s;
      af_r     <= af_nxt_s;
      ovf_r    <= ovf_nxt_s;
      unf_r    <= unf_nxt_s;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc_s && !clr) begin
      mem_r[wr_ptr_r[ADDR-1:0]] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem_r[rd_ptr_r[ADDR-1:0]];
    end else begin : g_reg
      logic [WIDTH-1:0] rdata_r;
      // Registered read data, updated only on an accepted read
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rdata_r <= '0;
        end else if (clr) begin
          rdata_r <= '0;
        end else if (rd_acc_s) begin
          rdata_r <= mem_r[rd_ptr_r[ADDR-1:0]];
        end else begin
          rdata_r <= rdata_r;
        end
      end
      assign rdata = rdata_r;
    end
  endgenerate

  assign fifo_empty   = empty_r;
  assign fifo_full    = full_r;
  assign almost_empty = ae_r;
  assign almost_full  = af_r;
  assign count        = count_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: registered-read and FWFT instances share stimulus and
// are checked against a queue-based model, a vector table and directed corner sequences.
module tb_sync_fifo_ext;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata0, rdata1;
  logic        empty0, full0, ae0, af0, ovf0, unf0;
  logic        empty1, full1, ae1, af1, ovf1, unf1;
  logic [4:0]  count0, count1;

  always #5 clk = ~clk;

  sync_fifo_ext #(.WIDTH(32), .ADDR(4), .FWFT(0), .AF_LVL(14), .AE_LVL(2)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata0), .fifo_empty(empty0), .fifo_full(full0), .almost_empty(ae0),
    .almost_full(af0), .count(count0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_ext #(.WIDTH(32), .ADDR(4), .FWFT(1), .AF_LVL(14), .AE_LVL(2)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wdata(wdata), .rd_en(rd_en),
    .rdata(rdata1), .fifo_empty(empty1), .fifo_full(full1), .almost_empty(ae1),
    .almost_full(af1), .count(count1), .overflow(ovf1), .underflow(unf1));

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: contents as a queue, plus sticky errors and registered read word
  logic [31:0] q[$];
  bit          m_ovf, m_unf;
  logic [31:0] m_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rdata = 32'h0;
  endtask

  task automatic model_update(input bit w, input bit r, input bit c, input logic [31:0] d);
    bit was_full, was_empty;
    if (c) begin
      model_reset();
    end else begin
      was_full  = (q.size() == 16);
      was_empty = (q.size() == 0);
      if (w && was_full) m_ovf = 1'b1;
      if (r && was_empty) m_unf = 1'b1;
      if (r && !was_empty) m_rdata = q.pop_front();
      if (w && !was_full) q.push_back(d);
    end
  endtask

  task automatic compare_model();
    check("count", {27'h0, count0}, q.size());
    check("empty", {31'h0, empty0}, {31'h0, q.size() == 0});
    check("full", {31'h0, full0}, {31'h0, q.size() == 16});
    check("almost_empty", {31'h0, ae0}, {31'h0, q.size() <= 2});
    check("almost_full", {31'h0, af0}, {31'h0, q.size() >= 14});
    check("overflow", {31'h0, ovf0}, {31'h0, m_ovf});
    check("underflow", {31'h0, unf0}, {31'h0, m_unf});
    check("rdata_reg", rdata0, m_rdata);
    check("fwft_empty", {31'h0, empty1}, {31'h0, q.size() == 0});
    check("fwft_count", {27'h0, count1}, q.size());
    if (q.size() > 0) check("rdata_fwft", rdata1, q[0]);
  endtask

  task automatic step(input bit w, input bit r, input bit c, input logic [31:0] d);
    wr_en = w; rd_en = r; clr = c; wdata = d;
    @(posedge clk);
    #1;
    model_update(w, r, c, d);
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    compare_model();
  endtask

  typedef struct {
    bit          wr;
    bit          rd;
    bit          clr;
    logic [31:0] d;
    int          cnt;
    bit          ovf;
    bit          unf;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int wp, rp;
    // Expected values written from the FIFO rules, starting from reset
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'hBEEF, 1, 1'b0, 1'b1, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,    0, 1'b0, 1'b1, 32'hBEEF};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h77,   0, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h11,   1, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h22,   2, 1'b0, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h33,   2, 1'b0, 1'b0, 32'h11};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,    1, 1'b0, 1'b0, 32'h22};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,    0, 1'b0, 1'b0, 32'h33};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h0,    0, 1'b0, 1'b1, 32'h33};

    // Reset values, applied asynchronously before any clock edge
    #1 rst = 1'b0;
    #2;
    model_reset();
    compare_model();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].d);
      check("tbl_count", {27'h0, count0}, tbl[i].cnt);
      check("tbl_ovf", {31'h0, ovf0}, {31'h0, tbl[i].ovf});
      check("tbl_unf", {31'h0, unf0}, {31'h0, tbl[i].unf});
      check("tbl_rdata", rdata0, tbl[i].rdat);
    end

    // Fill to full, watching threshold crossings
    step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h100 + i);
      check("fill_count", {27'h0, count0}, i + 1);
      check("fill_ae", {31'h0, ae0}, {31'h0, i < 2});
      check("fill_af", {31'h0, af0}, {31'h0, i >= 13});
      check("fill_full", {31'h0, full0}, {31'h0, i == 15});
    end
    // Write while full with a read: read wins, write dropped, overflow sticks
    step(1'b1, 1'b1, 1'b0, 32'hDEAD);
    check("ovf_count", {27'h0, count0}, 15);
    check("ovf_flag", {31'h0, ovf0}, 32'h1);
    check("ovf_rdata", rdata0, 32'h100);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      check("drain_rdata", rdata0, 32'h101 + i);
    end
    check("drain_empty", {31'h0, empty0}, 32'h1);

    // Steady occupancy of 8 with pointer wrap, then clear
    step(1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 32'h200 + i);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h300 + i);
      check("steady_count", {27'h0, count0}, 8);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    check("clr_count", {27'h0, count0}, 0);
    check("clr_empty", {31'h0, empty0}, 32'h1);

    // First-word-fall-through visibility
    step(1'b1, 1'b0, 1'b0, 32'hA5);
    check("fwft_visible", rdata1, 32'hA5);
    check("fwft_not_empty", {31'h0, empty1}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check("fwft_popped", {31'h0, empty1}, 32'h1);

    // Asynchronous reset mid-burst at count 9
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 32'h400 + i);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h409);
    check("pre_rst_count", {27'h0, count0}, 9);
    #2 rst = 1'b0;
    #1;
    check("arst_count", {27'h0, count0}, 0);
    check("arst_empty", {31'h0, empty0}, 32'h1);
    check("arst_ae", {31'h0, ae0}, 32'h1);
    check("arst_af", {31'h0, af0}, 32'h0);
    check("arst_rdata", rdata0, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic in phases biased toward full, empty and balanced
    for (int i = 0; i < 600; i++) begin
      case (i / 200)
        0:       begin wp = 80; rp = 30; end
        1:       begin wp = 30; rp = 80; end
        default: begin wp = 50; rp = 50; end
      endcase
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 63) == 0, $urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
